fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end that drives the word-aligned fetch port of the instruction memory and buffers the returned words for decode. It holds the program counter and a small in-order FIFO of {pc, instruction} pairs, and presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the new target. The instruction memory read is combinational, so one word is captured per cycle whenever buffer space exists.

## Interface

**Parameters**
- `ADDR_WIDTH`, 32: width of PC and fetch address.
- `DATA_WIDTH`, 32: instruction width.
- `DEPTH`, 4: FIFO entries. Power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset. Word aligned.

**Ports**
- `clk`  in  1  Clock; all state updates on its rising edge.
- `rst`  in  1  Reset, synchronous, active-high.
- `instr_addr`  out  ADDR_WIDTH  Fetch address to instruction memory. Equals the fetch PC, bits [1:0] always 0.
- `instr`  in  DATA_WIDTH  Word returned combinationally by instruction memory for `instr_addr`.
- `redirect_valid`  in  1  Execute requests a PC change this cycle.
- `redirect_pc`  in  ADDR_WIDTH  Redirect target.
- `out_valid`  out  1  Head entry is valid.
- `out_ready`  in  1  Decode accepts the head entry this cycle.
- `out_instr`  out  DATA_WIDTH  Head instruction. Reads 32'h0000_0013 (NOP) when `out_valid` = 0.
- `out_pc`  out  ADDR_WIDTH  PC of the head instruction. Reads 0 when `out_valid` = 0.
- `fetch_fault`  out  1  Sticky misaligned-redirect flag.

## Operation

**State**
- `fetch_pc`.
- FIFO storage of DEPTH × {pc, instr}.
- Read and write pointers, log2(DEPTH) bits, wrapping modulo DEPTH.
- `count`, log2(DEPTH)+1 bits.
- `fault` register.

**Cycle events**
- pop = `out_valid` & `out_ready`.
- push = !`fault` & (`count` < DEPTH | pop).
  - A push while full is allowed only when a pop happens in the same cycle.
- On push: write {`fetch_pc`, `instr`} at the write pointer, advance the write pointer, and set `fetch_pc` ← `fetch_pc` + 4.
  - The add is modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC wraps to 0.
- On pop: advance the read pointer.
- `count` ← `count` + push − pop. Push and pop together leave `count` unchanged.

**Redirect** (has priority over push and pop in the same cycle)
- The FIFO is flushed: pointers reset to 0, `count` = 0. Any pop or push in that cycle is discarded.
- If `redirect_pc[1:0]` == 0:
  - `fetch_pc` ← `redirect_pc`.
  - `fault` ← 0.
- Otherwise:
  - `fetch_pc` ← {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}.
  - `fault` ← 1.

**Fault behaviour**
- While `fault` = 1: no pushes occur and `out_valid` stays 0.
- `fault` clears only on reset or on an aligned redirect.

**Outputs**
- `out_valid` = (`count` != 0).
- `out_instr` and `out_pc` are driven combinationally from the head entry.
- `fetch_fault` = `fault`.

**Reset** (`rst` = 1 at an edge)
- `fetch_pc` = RESET_PC.
- Pointers = 0, `count` = 0, `fault` = 0.
- Outputs after reset: `out_valid` = 0, `out_instr` = 32'h13, `out_pc` = 0, `fetch_fault` = 0, `instr_addr` = RESET_PC.
- Reset overrides redirect.
- Reset in the middle of operation discards all buffered entries.

## Timing

- Fetch-to-decode latency is 1 cycle.
  - A word fetched at edge N (push) is visible at the head with `out_valid` = 1 after edge N.
  - Example: first instruction after reset release at edge R is presented from edge R+1.
- Redirect latency:
  - Redirect sampled at edge N: `out_valid` = 0 after edge N, and `instr_addr` = target.
  - The target instruction is presented after edge N+1.
- Sustained throughput is one instruction per cycle when `out_ready` is held high, including when the FIFO is full.
- Decode may hold `out_ready` low indefinitely. The head entry must remain stable while `out_valid` = 1 and `out_ready` = 0, unless a redirect or reset occurs.
- When the FIFO is full with no pop, `fetch_pc` and `instr_addr` hold.

## Test plan

1. **Reset and streaming.** Setup: RESET_PC = 0, memory word *k* = 32'h1000_0000 + *k*, `out_ready` = 1. Required:
   - First accepted beat is pc 0, instr 32'h1000_0000.
   - Every following cycle gives pc +4 and instr +1.
   - No bubbles after the first cycle.
2. **Backpressure and full.** Setup: `out_ready` = 0 for 10 cycles, then 1. Required:
   - `count` saturates at 4 and `instr_addr` holds at 0x10.
   - The head stays pc 0 throughout the stall.
   - After release, pcs 0, 4, 8, C, 10… are accepted in consecutive cycles.
3. **Redirect with simultaneous pop.** Setup: FIFO holding pcs 0–C; redirect to 0x100 in the same cycle as a pop. Required:
   - The next cycle shows `out_valid` = 0.
   - The cycle after shows pc 0x100.
   - Stale entries 4–C never appear on the output.
4. **Misaligned redirect.** Setup: redirect to 0x102. Required:
   - `fetch_fault` = 1 from the next cycle.
   - `out_valid` stays 0 for 20 cycles.
   - A later redirect to 0x200 clears the fault, and pc 0x200 appears 2 cycles after that redirect.
5. **PC wrap.** Setup: RESET_PC = 32'hFFFF_FFF8. Required: output pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
6. **Reset mid-stream.** Setup: assert `rst` for 1 cycle while the FIFO holds 3 entries and a redirect is also asserted. Required:
   - All outputs take their reset values.
   - The next accepted pc is RESET_PC.
   - The redirect target is ignored.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// Drives the word-aligned fetch port of a combinational instruction memory,
// buffers {pc, instr} pairs in a small in-order FIFO and hands them to decode
// over valid/ready. A redirect flushes the buffer and restarts fetch; a
// misaligned redirect target parks fetch in a sticky fault state.
module fetch_queue #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fetch_fault
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_fault;

    logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];

    logic                  w_head_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [ADDR_WIDTH-1:0] w_redirect_word;
    logic                  w_redirect_misaligned;

    // Handshake events and next fetch address for this cycle
    always_comb begin
        w_head_valid          = (r_count != '0);
        w_full                = (r_count == FULL_CNT);
        w_pop                 = w_head_valid & out_ready;
        // A full buffer still accepts a word when the head leaves this cycle
        w_push                = ~r_fault & (~w_full | w_pop);
        w_next_pc             = r_fetch_pc + ADDR_WIDTH'(4);
        w_redirect_word       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        w_redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    end

    // Entry storage: capture {fetch_pc, instr} at the write pointer on push
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= instr;
        end
    end

    // Fetch PC, pointers, occupancy and fault; redirect flushes and wins over push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fault    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_word;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fault    <= w_redirect_misaligned;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc <= w_next_pc;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head of the FIFO presented to decode; NOP / zero pc while empty
    always_comb begin
        instr_addr  = r_fetch_pc;
        out_valid   = w_head_valid;
        out_instr   = w_head_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
        out_pc      = w_head_valid ? r_pc_mem[r_rd_ptr] : '0;
        fetch_fault = r_fault;
    end

endmodule
